// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// word/offset widths and the captured-request payload.
package data_mem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BOFF_W = 2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } txn_t;

  // Misaligned byte address or word index past the end of the array.
  function automatic logic addr_bad(input logic [WORD_W-1:0] addr,
                                    input int unsigned       depth);
    addr_bad = (addr[BOFF_W-1:0] != '0) ||
               (32'(addr[WORD_W-1:BOFF_W]) >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed RAM: synchronous write, address-indexed read, no reset.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned AW          = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_c_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for core word load/store requests: req/ack handshake with a
// fixed number of wait states, alignment/range checking, local RAM.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  txn_t              txn_q, txn_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  txn_t              cur_c;
  logic              bad_c;
  logic              enter_resp_c;
  logic              mem_we_c;
  logic [WORD_W-1:0] mem_rdata_c;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk_i    (clk_i),
    .we_i     (mem_we_c),
    .addr_i   (cur_c.addr[AW+BOFF_W-1:BOFF_W]),
    .wdata_i  (cur_c.wdata),
    .rdata_c_o(mem_rdata_c)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      txn_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txn_q   <= txn_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    txn_d        = txn_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    rdata_d      = '0;
    busy_d       = 1'b0;
    cur_c        = txn_q;
    bad_c        = 1'b0;
    enter_resp_c = 1'b0;
    mem_we_c     = 1'b0;

    // With zero wait states RESP is entered on the acceptance edge itself,
    // so the live request must feed the array directly.
    if (state_q == ST_IDLE) begin
      cur_c.we    = we_i;
      cur_c.addr  = addr_i;
      cur_c.wdata = wdata_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          txn_d = cur_c;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    enter_resp_c = (state_d == ST_RESP) && (state_q != ST_RESP);
    bad_c        = addr_bad(cur_c.addr, DEPTH_WORDS);
    mem_we_c     = enter_resp_c && cur_c.we && !bad_c;

    if (enter_resp_c) begin
      ack_d   = 1'b1;
      err_d   = bad_c;
      rdata_d = (bad_c || cur_c.we) ? '0 : mem_rdata_c;
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: u0 runs with two wait states, u1 with none.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, ack0, err0, busy0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, we1, ack1, err1, busy1;
  logic [31:0] addr1, wdata1, rdata1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) u0 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .wdata_i(wdata0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0), .busy_o(busy0)
  );

  data_mem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) u1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wdata1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .busy_o(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] w);
    if (d == 0) begin
      req0 = req; we0 = we; addr0 = a; wdata0 = w;
    end else begin
      req1 = req; we1 = we; addr1 = a; wdata1 = w;
    end
  endtask

  task automatic sample(input int d, output logic ack, output logic err,
                        output logic busy, output logic [31:0] rd);
    if (d == 0) begin
      ack = ack0; err = err0; busy = busy0; rd = rdata0;
    end else begin
      ack = ack1; err = err1; busy = busy1; rd = rdata1;
    end
  endtask

  // One transaction: ack latency, ack-cycle outputs, then outputs cleared.
  task automatic txn(input int d, input string tag, input logic we,
                     input logic [31:0] a, input logic [31:0] w,
                     input logic exp_err, input logic [31:0] exp_rd, input bit mod);
    int          lat;
    int          n;
    logic        ack, err, busy;
    logic [31:0] rd;
    lat = (d == 0) ? 3 : 1;
    n   = 0;
    @(negedge clk);
    drive(d, 1'b1, we, a, w);
    @(posedge clk);
    do begin
      @(negedge clk);
      n++;
      if (mod && n == 1) drive(d, 1'b1, we, 32'h30, 32'h5555);
      sample(d, ack, err, busy, rd);
    end while (!ack && n < 20);
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    sample(d, ack, err, busy, rd);
    chk({tag, ".ack_off"}, 32'(ack), 32'd0);
    chk({tag, ".err_off"}, 32'(err), 32'd0);
    chk({tag, ".rdata_off"}, rd, 32'h0);
  endtask

  initial begin : stim
    logic        ack, err, busy;
    logic [31:0] rd;
    logic        ack_seen;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst.ack", 32'(ack0), 32'd0);
    chk("rst.err", 32'(err0), 32'd0);
    chk("rst.busy", 32'(busy0), 32'd0);
    chk("rst.rdata", rdata0, 32'h0);
    chk("rst.busy1", 32'(busy1), 32'd0);
    rst_n = 1'b1;

    // Store then load, two wait states.
    txn(0, "t1.st", 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    txn(0, "t1.ld", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Misaligned store rejected, memory untouched.
    txn(0, "t3.st", 1'b1, 32'h12, 32'h0BAD0BAD, 1'b1, 32'h0, 1'b0);
    txn(0, "t3.ld", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Word index 128 is one past the end.
    txn(0, "t4.ld", 1'b0, 32'h200, 32'h0, 1'b1, 32'h0, 1'b0);

    // Inputs changed during WAIT must not affect the accepted store.
    txn(0, "t5.pre", 1'b1, 32'h30, 32'h00000A0A, 1'b0, 32'h0, 1'b0);
    txn(0, "t5.st", 1'b1, 32'h8, 32'h00001234, 1'b0, 32'h0, 1'b1);
    txn(0, "t5.ld8", 1'b0, 32'h8, 32'h0, 1'b0, 32'h00001234, 1'b0);
    txn(0, "t5.ld30", 1'b0, 32'h30, 32'h0, 1'b0, 32'h00000A0A, 1'b0);

    // Zero wait states: back-to-back loads with req held high.
    txn(1, "t2.st0", 1'b1, 32'h0, 32'h00000011, 1'b0, 32'h0, 1'b0);
    txn(1, "t2.st4", 1'b1, 32'h4, 32'h00000022, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t2.ack_c1", 32'(ack1), 32'd1);
    chk("t2.rd_c1", rdata1, 32'h00000011);
    chk("t2.busy_c1", 32'(busy1), 32'd1);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    chk("t2.ack_c2", 32'(ack1), 32'd0);
    chk("t2.busy_c2", 32'(busy1), 32'd0);
    chk("t2.rd_c2", rdata1, 32'h0);
    @(negedge clk);
    chk("t2.ack_c3", 32'(ack1), 32'd1);
    chk("t2.rd_c3", rdata1, 32'h00000022);
    chk("t2.err_c3", 32'(err1), 32'd0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t2.ack_c4", 32'(ack1), 32'd0);

    // Reset during WAIT of a store aborts it without a write.
    txn(0, "t6.pre", 1'b1, 32'h20, 32'h00001111, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h0000FFFF);
    @(posedge clk);
    @(negedge clk);
    chk("t6.wait_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    sample(0, ack, err, busy, rd);
    chk("t6.rst_ack", 32'(ack), 32'd0);
    chk("t6.rst_busy", 32'(busy), 32'd0);
    chk("t6.rst_err", 32'(err), 32'd0);
    chk("t6.rst_rdata", rd, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ack_seen = ack_seen | ack0;
    end
    chk("t6.no_ack", 32'(ack_seen), 32'd0);
    rst_n = 1'b1;
    txn(0, "t6.ld", 1'b0, 32'h20, 32'h0, 1'b0, 32'h00001111, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
